uart_rx_ovs_fifo: RTL and testbench
===================================

UART_RX_OVS_FIFO -- requirements
Module: uart_rx_ovs_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries; power of two, at least 4.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor.
REQ-003 SHALL have parameter RTS_MARGIN, default 2: free-entry threshold for rts_n.
REQ-004 SHALL have the following ports (clock and reset first):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input; asynchronous, idle high.
- cfg_div  in  DIV_WIDTH  clk cycles per oversample tick; value 0 is treated as 1.
- cfg_data_bits  in  2  0..3 selects 5..8 data bits.
- cfg_stop_bit  in  1  0 = one stop bit, 1 = two stop bits.
- cfg_parity_en  in  1  parity bit present.
- cfg_parity_even  in  1  1 = even parity, 0 = odd parity.
- rd_en  in  1  pop the FIFO head.
- ovr_clr  in  1  clear the overrun flag.
- rd_data  out  8  FIFO head data; right-justified, unused upper bits 0.
- rd_perr  out  1  parity error flag of the head entry.
- rd_ferr  out  1  framing error flag of the head entry.
- rd_brk  out  1  break flag of the head entry.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overrun  out  1  sticky: a frame was dropped.
- rts_n  out  1  flow control; low means ready to receive.

Function
REQ-005 SHALL pass rx through a 2-flop synchronizer; all line decisions use the synchronized value.
REQ-006 SHALL produce a one-cycle tick every max(cfg_div,1) clk cycles; 16 ticks make one bit time.
REQ-007 SHALL use the FSM states IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
REQ-008 In IDLE, a synchronized falling edge SHALL move the FSM to START, reset the tick counter, and latch all cfg_* inputs; cfg changes made mid-frame SHALL have no effect on that frame.
REQ-009 Each bit value SHALL be the majority vote of samples 7, 8 and 9 of the 16 samples in that bit.
REQ-010 If the start-bit vote is 1, the FSM SHALL return to IDLE and push nothing (glitch rejection).
REQ-011 Data bits SHALL be received LSB first, 5..8 of them as latched, and stored right-justified.
REQ-012 The PARITY state SHALL be entered only if parity is enabled.
- perr = 1 when the XOR of the data bits and the parity bit is 1 (even parity) or 0 (odd parity).
REQ-013 A stop-bit vote of 0 in STOP1 SHALL set ferr; STOP2 SHALL be entered only if cfg_stop_bit was latched as 1, and a 0 vote there SHALL also set ferr.
REQ-014 brk SHALL be 1 when the data bits, the parity bit (if present) and the first stop bit are all 0; brk implies ferr.
REQ-015 The push of {brk, ferr, perr, data} SHALL occur on the clk edge of the sample-9 tick of the last stop bit.
- empty falls on that same edge.
REQ-016 After the push, if ferr = 1 the FSM SHALL go to WAIT_HIGH and stay there until the synchronized rx is 1; otherwise it SHALL go to IDLE.
REQ-017 The FIFO SHALL be first-word-fall-through: the rd_* outputs show the head whenever empty = 0.
- rd_en pops the head on the clk edge.
- rd_en while empty is ignored.
REQ-018 A push while full SHALL drop the frame and set overrun; overrun stays 1 until an ovr_clr pulse.
- If ovr_clr coincides with a new overrun, the set wins.
REQ-019 A push and a pop in the same cycle while full SHALL both succeed, with level unchanged.
- While empty, the push succeeds and the pop is ignored.
REQ-020 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level = write count minus read count.
REQ-021 rts_n SHALL be registered and equal 1 when level >= FIFO_DEPTH - RTS_MARGIN, else 0.

Reset
REQ-022 While rst_n = 0, regardless of clk:
- FSM is in IDLE; synchronizer flops are 1; tick and FIFO counters are 0.
- empty = 1, full = 0, level = 0, overrun = 0, rts_n = 0, rd_data/rd_perr/rd_ferr/rd_brk = 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame and all FIFO contents; the first falling edge after release starts a new frame.

Verification
REQ-024 8N1, cfg_div = 1, send 0xA5 -> after 9.5 bit times (152 clk ± 3): empty = 0, rd_data = 0xA5, rd_perr = rd_ferr = rd_brk = 0.
REQ-025 8E1, send 0xB6 with parity bit 0 -> rd_perr = 1, rd_data = 0xB6; the same frame with parity bit 1 -> rd_perr = 0.
REQ-026 7 data bits, 2 stop bits, send 0x53 with second stop bit 0 -> rd_data = 0x53, rd_ferr = 1; the line held low afterwards -> no further entries until rx returns high.
REQ-027 FIFO_DEPTH = 4, send 0x11..0x55 with no reads:
- full = 1, overrun = 1, rts_n = 1 once level reaches 2.
- Reads return 0x11, 0x22, 0x33, 0x44; 0x55 is absent.
- ovr_clr clears overrun.
REQ-028 rx low for 4 ticks, then high -> no push, FSM back in IDLE; all-zero 8N1 frame -> rd_data = 0x00, rd_ferr = 1, rd_brk = 1.
REQ-029 rst_n pulsed low during DATA with 2 entries queued -> empty = 1, level = 0; the next frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_ovs_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ovs_fifo
// Description : 16x oversampling UART receiver with configurable frame format
//               (5..8 data bits, optional parity, 1 or 2 stop bits), break and
//               framing detection, and a first-word-fall-through receive FIFO
//               with sticky overrun and registered RTS flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ovs_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int RTS_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_stop_bit,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_even,
  input  logic                          rd_en,
  input  logic                          ovr_clr,
  output logic [7:0]                    rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic                          rd_brk,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic                          rts_n
);

  localparam int            c_AW      = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_DEPTH   = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [c_AW:0] c_RTS_THR = (c_AW+1)'(FIFO_DEPTH - RTS_MARGIN);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP1     = 3'd4,
    STOP2     = 3'd5,
    WAIT_HIGH = 3'd6
  } state_t;

  state_t r_state, w_state_next;

  // --------------------------------------------------------------------------
  // Line synchronizer
  // --------------------------------------------------------------------------
  logic r_rx_meta, r_rx_sync, r_rx_prev;
  logic w_fall;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // --------------------------------------------------------------------------
  // Per-frame configuration snapshot
  // --------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] r_div;
  logic [1:0]           r_nbits;
  logic                 r_stop2;
  logic                 r_par_en;
  logic                 r_par_even;
  logic                 w_frame_start;

  assign w_frame_start = (r_state == IDLE) & w_fall;

  // Configuration is frozen at the start edge so mid-frame changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_nbits    <= '0;
      r_stop2    <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_even <= 1'b0;
    end else if (w_frame_start) begin
      r_div      <= cfg_div;
      r_nbits    <= cfg_data_bits;
      r_stop2    <= cfg_stop_bit;
      r_par_en   <= cfg_parity_en;
      r_par_even <= cfg_parity_even;
    end
  end

  // --------------------------------------------------------------------------
  // Oversample tick and sample position
  // --------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [DIV_WIDTH-1:0] w_div_eff;
  logic [3:0]           r_smp;       // index of the last sample taken (0..15)
  logic [3:0]           w_smp_next;
  logic                 w_active;
  logic                 w_tick;

  assign w_div_eff  = (r_div == '0) ? DIV_WIDTH'(1) : r_div;
  assign w_active   = (r_state != IDLE) && (r_state != WAIT_HIGH);
  assign w_tick     = w_active && (r_div_cnt == (w_div_eff - DIV_WIDTH'(1)));
  assign w_smp_next = r_smp + 4'd1;

  // Tick divider and sample index; the detection edge already lags the line
  // by the synchronizer, so it is counted as the second sample of the start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_smp     <= '0;
    end else if (!w_active) begin
      r_div_cnt <= '0;
      r_smp     <= w_frame_start ? 4'd1 : 4'd0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_smp     <= w_smp_next;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Majority vote over samples 7, 8 and 9
  // --------------------------------------------------------------------------
  logic r_s7, r_s8;
  logic w_s9;
  logic w_vote;

  assign w_s9   = w_tick && (w_smp_next == 4'd8);
  assign w_vote = (r_s7 & r_s8) | (r_s7 & r_rx_sync) | (r_s8 & r_rx_sync);

  // Capture the first two voting samples of each bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s7 <= 1'b0;
      r_s8 <= 1'b0;
    end else if (w_tick) begin
      if (w_smp_next == 4'd6) r_s7 <= r_rx_sync;
      if (w_smp_next == 4'd7) r_s8 <= r_rx_sync;
    end
  end

  // --------------------------------------------------------------------------
  // Frame datapath
  // --------------------------------------------------------------------------
  logic [7:0] r_data;
  logic [2:0] r_bit_cnt;
  logic       r_perr;
  logic       r_ferr;
  logic       r_brk;
  logic       r_seen_one;   // any 1 among data/parity bits so far
  logic       w_last_data;
  logic       w_ferr_push;
  logic       w_brk_push;

  assign w_last_data = (r_bit_cnt == ({1'b0, r_nbits} + 3'd4));
  assign w_ferr_push = (r_state == STOP1) ? ~w_vote : (r_ferr | ~w_vote);
  assign w_brk_push  = (r_state == STOP1) ? (~r_seen_one & ~w_vote) : r_brk;

  // Assemble data and error flags as each bit's vote is resolved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
      r_seen_one <= 1'b0;
    end else if (w_frame_start) begin
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
      r_seen_one <= 1'b0;
    end else if (w_s9) begin
      case (r_state)
        DATA: begin
          r_data[r_bit_cnt] <= w_vote;
          r_bit_cnt         <= r_bit_cnt + 3'd1;
          r_seen_one        <= r_seen_one | w_vote;
        end
        PARITY: begin
          r_perr     <= ((^r_data) ^ w_vote) == r_par_even;
          r_seen_one <= r_seen_one | w_vote;
        end
        STOP1: begin
          r_ferr <= ~w_vote;
          r_brk  <= ~r_seen_one & ~w_vote;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  logic w_push;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and push decision, resolved on each bit's sample-9 tick
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      IDLE:      if (w_fall) w_state_next = START;
      START:     if (w_s9) w_state_next = w_vote ? IDLE : DATA;
      DATA:      if (w_s9 && w_last_data) w_state_next = r_par_en ? PARITY : STOP1;
      PARITY:    if (w_s9) w_state_next = STOP1;
      STOP1: begin
        if (w_s9) begin
          if (r_stop2) begin
            w_state_next = STOP2;
          end else begin
            w_push       = 1'b1;
            w_state_next = w_ferr_push ? WAIT_HIGH : IDLE;
          end
        end
      end
      STOP2: begin
        if (w_s9) begin
          w_push       = 1'b1;
          w_state_next = w_ferr_push ? WAIT_HIGH : IDLE;
        end
      end
      WAIT_HIGH: if (r_rx_sync) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [10:0]   r_mem [FIFO_DEPTH];
  logic [c_AW:0] r_wr_cnt, r_rd_cnt;
  logic [c_AW:0] w_level, w_level_next;
  logic [10:0]   w_push_word, w_head;
  logic          w_empty, w_full, w_pop, w_wr, w_ovr_set;
  logic          r_overrun, r_rts_n;

  assign w_push_word  = {w_brk_push, w_ferr_push, r_perr, r_data};
  assign w_level      = r_wr_cnt - r_rd_cnt;
  assign w_empty      = (w_level == '0);
  assign w_full       = (w_level == c_DEPTH);
  assign w_pop        = rd_en & ~w_empty;
  assign w_wr         = w_push & (~w_full | w_pop);
  assign w_ovr_set    = w_push & w_full & ~w_pop;
  assign w_level_next = w_level + {{c_AW{1'b0}}, w_wr} - {{c_AW{1'b0}}, w_pop};

  // Storage array; written only for accepted pushes
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_cnt[c_AW-1:0]] <= w_push_word;
  end

  // Free-running write/read counts; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr)  r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_pop) r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  // Sticky overrun (set beats clear) and RTS tracking the post-edge level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_rts_n   <= 1'b0;
    end else begin
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;
      r_rts_n <= (w_level_next >= c_RTS_THR);
    end
  end

  assign w_head  = w_empty ? 11'd0 : r_mem[r_rd_cnt[c_AW-1:0]];
  assign rd_data = w_head[7:0];
  assign rd_perr = w_head[8];
  assign rd_ferr = w_head[9];
  assign rd_brk  = w_head[10];
  assign empty   = w_empty;
  assign full    = w_full;
  assign level   = w_level;
  assign overrun = r_overrun;
  assign rts_n   = r_rts_n;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ovs_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ovs_fifo
// Description : Directed self-checking bench for uart_rx_ovs_fifo. A queue
//               model of received frames is compared against the DUT outputs
//               on every falling clock edge; literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_ovs_fifo;

  localparam int DEPTH  = 4;
  localparam int MARGIN = 2;
  localparam int DW     = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx = 1'b1;
  logic [DW-1:0] cfg_div = 16'd1;
  logic [1:0]    cfg_data_bits = 2'd3;
  logic          cfg_stop_bit = 1'b0;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_even = 1'b0;
  logic          rd_en = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_perr, rd_ferr, rd_brk;
  logic          empty, full, overrun, rts_n;
  logic [2:0]    level;

  uart_rx_ovs_fifo #(
    .FIFO_DEPTH(DEPTH),
    .DIV_WIDTH (DW),
    .RTS_MARGIN(MARGIN)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx             (rx),
    .cfg_div        (cfg_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_stop_bit   (cfg_stop_bit),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_even(cfg_parity_even),
    .rd_en          (rd_en),
    .ovr_clr        (ovr_clr),
    .rd_data        (rd_data),
    .rd_perr        (rd_perr),
    .rd_ferr        (rd_ferr),
    .rd_brk         (rd_brk),
    .empty          (empty),
    .full           (full),
    .level          (level),
    .overrun        (overrun),
    .rts_n          (rts_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_start = 0;
  int t_push  = 0;
  bit prev_empty = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: queue of received entries, sticky overrun flag
  typedef struct packed {
    logic       brk;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_ovr = 1'b0;
  bit   hold  = 1'b0;   // set while the push instant of a frame is in flight

  // Cycle compare of every output against the model
  always @(negedge clk) begin : p_cmp
    ent_t head;
    int   sz;
    bit   ok;
    if (!hold) begin
      sz   = mq.size();
      head = (sz > 0) ? mq[0] : '0;
      ok   = (empty === (sz == 0)) && (full === (sz == DEPTH)) &&
             (int'(level) == sz) && (overrun === m_ovr) &&
             (rts_n === (sz >= DEPTH - MARGIN)) &&
             (rd_data === head.data) && (rd_perr === head.perr) &&
             (rd_ferr === head.ferr) && (rd_brk === head.brk);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t: dut e/f/lvl/ovr/rts=%b/%b/%0d/%b/%b head=%h b%b f%b p%b ; required e/f/lvl/ovr/rts=%b/%b/%0d/%b/%b head=%h b%b f%b p%b",
                 $time, empty, full, level, overrun, rts_n, rd_data, rd_brk, rd_ferr, rd_perr,
                 sz == 0, sz == DEPTH, sz, m_ovr, sz >= DEPTH - MARGIN, head.data, head.brk, head.ferr, head.perr);
      end
    end
  end

  // Timestamp of each empty -> non-empty transition
  always @(negedge clk) begin
    if (prev_empty && !empty) t_push = cyc;
    prev_empty = empty;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    step(n);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clr_ovr();
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Serialise one frame using the current cfg; optionally disturb cfg mid-frame
  task automatic send_frame(input logic [7:0] d, input bit pbit, input bit s1,
                            input bit s2, input bit scramble);
    bit         bits[$];
    int         bt, nb, nstop;
    bit         pen, peven;
    logic [7:0] mask, dm;
    ent_t       e;
    logic [DW-1:0] o_div;
    logic [1:0] o_nb;
    logic       o_st, o_pe, o_pv;
    o_div = cfg_div; o_nb = cfg_data_bits; o_st = cfg_stop_bit;
    o_pe = cfg_parity_en; o_pv = cfg_parity_even;
    bt    = 16 * ((cfg_div == 0) ? 1 : int'(cfg_div));
    nb    = int'(cfg_data_bits) + 5;
    nstop = cfg_stop_bit ? 2 : 1;
    pen   = cfg_parity_en;
    peven = cfg_parity_even;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(s1);
    if (nstop == 2) bits.push_back(s2);
    t_start = cyc;
    for (int i = 0; i < bits.size(); i++) begin
      if (i == bits.size() - 1) hold = 1'b1;
      rx = bits[i];
      if (i == 1 && scramble) begin
        cfg_div = 16'd5; cfg_data_bits = ~o_nb; cfg_stop_bit = ~o_st;
        cfg_parity_en = ~o_pe; cfg_parity_even = ~o_pv;
      end
      step(bt);
    end
    cfg_div = o_div; cfg_data_bits = o_nb; cfg_stop_bit = o_st;
    cfg_parity_en = o_pe; cfg_parity_even = o_pv;
    mask   = 8'hFF >> (8 - nb);
    dm     = d & mask;
    e.data = dm;
    e.perr = pen && (((^dm) ^ pbit) == peven);
    e.ferr = !s1 || (nstop == 2 && !s2);
    e.brk  = (dm == 8'h00) && (!pen || !pbit) && !s1;
    if (mq.size() == DEPTH) m_ovr = 1'b1;
    else                    mq.push_back(e);
    hold = 1'b0;
  endtask

  initial begin
    int lat;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty",   empty,   1);
    chk("reset_full",    full,    0);
    chk("reset_level",   level,   0);
    chk("reset_overrun", overrun, 0);
    chk("reset_rts_n",   rts_n,   0);
    chk("reset_rd",      {rd_brk, rd_ferr, rd_perr, rd_data}, 0);
    rst_n = 1'b1;
    step(20);

    // 8N1 at divisor 1: latency and content
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    lat = t_push - t_start;
    n_tests++;
    if (lat < 149 || lat > 155) begin
      n_fail++;
      $display("FAIL push_latency: got %0d clk required 149..155", lat);
    end
    chk("a5_empty", empty, 0);
    chk("a5_data",  rd_data, 8'hA5);
    chk("a5_flags", {rd_brk, rd_ferr, rd_perr}, 3'b000);
    idle(20);
    pop();
    chk("a5_popped", empty, 1);

    // Divisor 0 behaves as 1; cfg disturbed mid-frame must not matter
    cfg_div = 16'd0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("latched_cfg_data", rd_data, 8'h5A);
    pop();

    // 5O1 at divisor 3: good parity, then masked upper bits with bad parity
    cfg_div = 16'd3; cfg_data_bits = 2'd0; cfg_parity_en = 1'b1; cfg_parity_even = 1'b0;
    send_frame(8'h15, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(60);
    send_frame(8'hF5, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(60);
    chk("5o1_good",  {rd_perr, rd_data}, {1'b0, 8'h15});
    pop();
    chk("5o1_bad",   {rd_perr, rd_data}, {1'b1, 8'h15});
    pop();

    // 8E1: parity bit 0 is wrong for 0xB6, parity bit 1 is right
    cfg_div = 16'd1; cfg_data_bits = 2'd3; cfg_parity_even = 1'b1;
    send_frame(8'hB6, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(20);
    send_frame(8'hB6, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(20);
    chk("8e1_perr1", {rd_perr, rd_data}, {1'b1, 8'hB6});
    pop();
    chk("8e1_perr0", {rd_perr, rd_data}, {1'b0, 8'hB6});
    pop();

    // 7N2 with bad second stop bit, line then held low
    cfg_data_bits = 2'd2; cfg_parity_en = 1'b0; cfg_stop_bit = 1'b1;
    send_frame(8'h53, 1'b0, 1'b1, 1'b0, 1'b0);
    step(16 * 12);
    chk("7n2_level_low", level, 1);
    chk("7n2_entry", {rd_brk, rd_ferr, rd_data}, {1'b0, 1'b1, 8'h53});
    idle(40);
    chk("7n2_level_high", level, 1);
    pop();

    // Start-bit glitch of 4 ticks, then an all-zero break frame
    cfg_data_bits = 2'd3; cfg_stop_bit = 1'b0;
    rx = 1'b0;
    step(4);
    idle(16 * 12);
    chk("glitch_empty", empty, 1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    chk("break_entry", {rd_brk, rd_ferr, rd_perr, rd_data}, {3'b110, 8'h00});
    pop();

    // Fill a depth-4 FIFO with five frames and no reads
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i * 17), 1'b0, 1'b1, 1'b1, 1'b0);
      idle(20);
      if (i == 1) chk("rts_lvl1", rts_n, 0);
      if (i == 2) chk("rts_lvl2", rts_n, 1);
    end
    chk("ovf_full",    full,    1);
    chk("ovf_overrun", overrun, 1);
    chk("ovf_level",   level,   4);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_read", rd_data, 8'(i * 17));
      pop();
    end
    chk("ovf_drained", empty, 1);
    chk("ovf_sticky", overrun, 1);
    clr_ovr();
    chk("ovf_cleared", overrun, 0);

    // Reset pulse mid-DATA with two entries queued
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h02, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(20);
    chk("pre_reset_level", level, 2);
    rx = 1'b0;
    step(16);
    rx = 1'b1;
    step(16 * 2 + 8);
    rst_n = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    step(3);
    chk("midreset_empty", empty, 1);
    chk("midreset_level", level, 0);
    rst_n = 1'b1;
    idle(40);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(20);
    chk("post_reset_data", {rd_brk, rd_ferr, rd_perr, rd_data}, {3'b000, 8'h3C});
    pop();
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
